mem_arbiter: RTL and testbench

Shares the single 16-bit SDRAM port of the `memory` block between three requesters: video refresh fetch, disk-copy DMA and the CPU bus. Grants are fixed-priority (video > copy > CPU), with a starvation guard that forces a CPU grant. A timeout watchdog keeps a stalled memory access from hanging the CPU. It sits between `memory`'s external port and the `video`, `disk` and CPU bus-decode logic in the top level, all in the `clk_sys` domain.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one SDRAM port between video, disk-copy and CPU: fixed priority with a CPU starvation guard.
// Request in IDLE at t gives mem_req at t+1 and ack one cycle after mem_ready (or after the WAIT timeout); losers simply wait.
module mem_arbiter #(
    parameter int AW      = 25,
    parameter int STARVE  = 4,
    parameter int TIMEOUT = 63
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [15:0]   vid_data,

    input  logic          cp_req,
    input  logic          cp_we,
    input  logic [AW-1:0] cp_addr,
    input  logic [15:0]   cp_din,
    output logic          cp_ack,
    output logic [15:0]   cp_dout,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_wtbt,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_din,
    output logic          cpu_ack,
    output logic [15:0]   cpu_dout,

    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    input  logic [15:0]   mem_dout,
    input  logic          mem_ready,

    output logic          timeout_err
);
    localparam int            SW         = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_VID, OWN_CP, OWN_CPU} owner_t;

    state_t        state_q;
    owner_t        owner_q;
    owner_t        owner_d;
    logic [SW-1:0] starve_q;
    logic [7:0]    tmo_q;

    logic          any_req;
    logic          rsp_fire;
    logic          rsp_tmo;
    logic [15:0]   rsp_dat;

    always_comb begin
        any_req = vid_req | cp_req | cpu_req;
        if (cpu_req && starve_q == STARVE_MAX) begin
            owner_d = OWN_CPU;
        end else if (vid_req) begin
            owner_d = OWN_VID;
        end else if (cp_req) begin
            owner_d = OWN_CP;
        end else begin
            owner_d = OWN_CPU;
        end
        // mem_ready wins over a timeout expiring in the same cycle
        rsp_fire = (state_q == S_WAIT) && (mem_ready || tmo_q == TMO_LAST);
        rsp_tmo  = (state_q == S_WAIT) && !mem_ready && (tmo_q == TMO_LAST);
        rsp_dat  = mem_ready ? mem_dout : 16'hFFFF;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_VID;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_addr    <= '0;
            mem_din     <= '0;
            vid_ack     <= 1'b0;
            cp_ack      <= 1'b0;
            cpu_ack     <= 1'b0;
            vid_data    <= '0;
            cp_dout     <= '0;
            cpu_dout    <= '0;
            timeout_err <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            vid_ack <= 1'b0;
            cp_ack  <= 1'b0;
            cpu_ack <= 1'b0;
            if (!cpu_req) begin
                starve_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q <= owner_d;
                        mem_req <= 1'b1;
                        state_q <= S_ISSUE;
                        case (owner_d)
                            OWN_VID: begin
                                mem_addr <= vid_addr;
                                mem_we   <= 1'b0;
                                mem_be   <= 2'b11;
                                mem_din  <= '0;
                            end
                            OWN_CP: begin
                                mem_addr <= cp_addr;
                                mem_we   <= cp_we;
                                mem_be   <= 2'b11;
                                mem_din  <= cp_din;
                            end
                            default: begin
                                mem_addr <= cpu_addr;
                                mem_we   <= cpu_we;
                                mem_be   <= cpu_wtbt;
                                mem_din  <= cpu_din;
                            end
                        endcase
                        if (owner_d == OWN_CPU) begin
                            starve_q <= '0;
                        end else if (cpu_req && starve_q != STARVE_MAX) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (rsp_fire) begin
                        state_q <= S_DONE;
                        if (rsp_tmo) begin
                            timeout_err <= 1'b1;
                        end
                        case (owner_q)
                            OWN_VID: begin
                                vid_ack  <= 1'b1;
                                vid_data <= rsp_dat;
                            end
                            OWN_CP: begin
                                cp_ack  <= 1'b1;
                                cp_dout <= rsp_dat;
                            end
                            default: begin
                                cpu_ack  <= 1'b1;
                                cpu_dout <= rsp_dat;
                            end
                        endcase
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                // DONE: the ack is already out, one idle gap lets the requester drop req
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_mem_arbiter;
    localparam int AW      = 25;
    localparam int STARVE  = 4;
    localparam int TIMEOUT = 63;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          vid_req, cp_req, cp_we, cpu_req, cpu_we;
    logic [AW-1:0] vid_addr, cp_addr, cpu_addr;
    logic [15:0]   cp_din, cpu_din;
    logic [1:0]    cpu_wtbt;
    logic          vid_ack, cp_ack, cpu_ack;
    logic [15:0]   vid_data, cp_dout, cpu_dout;
    logic          mem_req, mem_we, mem_ready;
    logic [1:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din, mem_dout;
    logic          timeout_err;

    mem_arbiter #(.AW(AW), .STARVE(STARVE), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .cp_req(cp_req), .cp_we(cp_we), .cp_addr(cp_addr), .cp_din(cp_din),
        .cp_ack(cp_ack), .cp_dout(cp_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wtbt(cpu_wtbt), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- model: owner chosen by priority rules, completion by cycle arithmetic
    int m_busy = 0, m_issue = 0, m_done = -1, m_own = 0, m_starve = 0;
    int mc, mw;
    logic [15:0]   md;
    logic          e_mem_req = 0, e_mem_we = 0, e_vid_ack = 0, e_cp_ack = 0, e_cpu_ack = 0, e_err = 0;
    logic [1:0]    e_mem_be = 0;
    logic [AW-1:0] e_mem_addr = 0;
    logic [15:0]   e_mem_din = 0, e_vid_data = 0, e_cp_dout = 0, e_cpu_dout = 0;

    initial forever begin
        @(posedge clk_sys);
        mc = cyc;
        e_mem_req = 0; e_vid_ack = 0; e_cp_ack = 0; e_cpu_ack = 0;
        if (reset) begin
            m_busy = 0; m_done = -1; m_starve = 0;
            e_mem_we = 0; e_mem_be = 0; e_mem_addr = 0; e_mem_din = 0;
            e_vid_data = 0; e_cp_dout = 0; e_cpu_dout = 0; e_err = 0;
        end else begin
            if (!cpu_req) m_starve = 0;
            if (m_busy == 0) begin
                if (vid_req || cp_req || cpu_req) begin
                    if (cpu_req && m_starve == STARVE) mw = 2;
                    else if (vid_req) mw = 0;
                    else if (cp_req) mw = 1;
                    else mw = 2;
                    if (mw == 2) m_starve = 0;
                    else if (cpu_req && m_starve < STARVE) m_starve++;
                    m_busy = 1; m_issue = mc + 1; m_done = -1; m_own = mw; e_mem_req = 1;
                    case (mw)
                        0: begin e_mem_addr = vid_addr; e_mem_we = 0; e_mem_be = 2'b11; e_mem_din = 0; end
                        1: begin e_mem_addr = cp_addr; e_mem_we = cp_we; e_mem_be = 2'b11; e_mem_din = cp_din; end
                        default: begin e_mem_addr = cpu_addr; e_mem_we = cpu_we; e_mem_be = cpu_wtbt; e_mem_din = cpu_din; end
                    endcase
                end
            end else if (m_done == mc) begin
                m_busy = 0;
            end else if (m_done < 0 && mc > m_issue && (mem_ready || mc - m_issue == TIMEOUT)) begin
                m_done = mc + 1;
                md = mem_ready ? mem_dout : 16'hFFFF;
                if (!mem_ready) e_err = 1;
                case (m_own)
                    0: begin e_vid_ack = 1; e_vid_data = md; end
                    1: begin e_cp_ack = 1; e_cp_dout = md; end
                    default: begin e_cpu_ack = 1; e_cpu_dout = md; end
                endcase
            end
        end
        cyc = mc + 1;
    end

    initial forever begin
        @(negedge clk_sys);
        if (chk_en) begin
            chk("mem_req", 32'(mem_req), 32'(e_mem_req));
            chk("mem_we", 32'(mem_we), 32'(e_mem_we));
            chk("mem_be", 32'(mem_be), 32'(e_mem_be));
            chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
            chk("mem_din", 32'(mem_din), 32'(e_mem_din));
            chk("vid_ack", 32'(vid_ack), 32'(e_vid_ack));
            chk("cp_ack", 32'(cp_ack), 32'(e_cp_ack));
            chk("cpu_ack", 32'(cpu_ack), 32'(e_cpu_ack));
            chk("vid_data", 32'(vid_data), 32'(e_vid_data));
            chk("cp_dout", 32'(cp_dout), 32'(e_cp_dout));
            chk("cpu_dout", 32'(cpu_dout), 32'(e_cpu_dout));
            chk("timeout_err", 32'(timeout_err), 32'(e_err));
        end
    end

    // ---------------- mem_req log
    int req_q[$];
    initial forever begin
        @(negedge clk_sys);
        if (mem_req === 1'b1) req_q.push_back(cyc);
    end

    // ---------------- memory responder
    bit          resp_on = 0;
    bit          resp_mode = 0;
    int          resp_k = 1;
    logic [15:0] resp_val = 0;
    int          kick_cnt = 0;
    initial begin
        int kick_seen;
        logic [15:0] rd;
        kick_seen = 0;
        mem_ready = 0;
        mem_dout = 0;
        forever begin
            @(negedge clk_sys);
            if (mem_req === 1'b1 && resp_on) begin
                rd = resp_mode ? resp_val : (mem_addr[15:0] ^ 16'hA5A5);
                repeat (resp_k) @(posedge clk_sys);
                #1; mem_ready = 1; mem_dout = rd;
                @(posedge clk_sys); #1; mem_ready = 0; mem_dout = 0;
            end else if (kick_cnt != kick_seen) begin
                kick_seen = kick_cnt;
                @(posedge clk_sys); #1; mem_ready = 1; mem_dout = 16'h7777;
                @(posedge clk_sys); #1; mem_ready = 0; mem_dout = 0;
            end
        end
    end

    // ---------------- requester side
    int ack_who[$];
    int ack_at[$];

    task automatic serve(input int n_acks, input int budget, input bit keep_vid);
        int got;
        bit av, ap, ac;
        got = 0;
        for (int i = 0; i < budget && got < n_acks; i++) begin
            @(negedge clk_sys);
            av = vid_ack; ap = cp_ack; ac = cpu_ack;
            if (av) begin ack_who.push_back(0); ack_at.push_back(cyc); got++; end
            if (ap) begin ack_who.push_back(1); ack_at.push_back(cyc); got++; end
            if (ac) begin ack_who.push_back(2); ack_at.push_back(cyc); got++; end
            @(posedge clk_sys); #1;
            if (av && !keep_vid) vid_req = 0;
            if (ap) cp_req = 0;
            if (ac) cpu_req = 0;
        end
        chk("acks_within_budget", 32'(got), 32'(n_acks));
    endtask

    task automatic count_acks(input int n, output int na);
        na = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            if (vid_ack || cp_ack || cpu_ack) na++;
        end
    endtask

    initial begin
        #300000;
        n_bad++;
        $display("FAIL global_time_limit: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int t, n0, na, found;
        reset = 1;
        vid_req = 0; cp_req = 0; cp_we = 0; cpu_req = 0; cpu_we = 0;
        vid_addr = 0; cp_addr = 0; cpu_addr = 0; cp_din = 0; cpu_din = 0; cpu_wtbt = 2'b11;
        @(posedge clk_sys); #1;
        chk_en = 1;
        @(negedge clk_sys);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_cpu_dout", 32'(cpu_dout), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        @(posedge clk_sys); #1;
        reset = 0;
        @(posedge clk_sys); #1;

        // single CPU read, k=3
        resp_on = 1; resp_mode = 1; resp_val = 16'hBEEF; resp_k = 3;
        cpu_addr = 25'h1000; cpu_we = 0; cpu_wtbt = 2'b11;
        ack_who.delete(); ack_at.delete();
        n0 = req_q.size(); t = cyc; cpu_req = 1;
        serve(1, 50, 0);
        chk("rd_req_count", 32'(req_q.size() - n0), 1);
        if (req_q.size() > n0) chk("rd_req_cycle", 32'(req_q[n0]), 32'(t + 1));
        if (ack_at.size() > 0) chk("rd_ack_cycle", 32'(ack_at[0]), 32'(t + 5));
        if (ack_who.size() > 0) chk("rd_ack_owner", 32'(ack_who[0]), 2);
        chk("rd_data", 32'(cpu_dout), 32'h0000BEEF);
        @(posedge clk_sys); #1;

        // simultaneous requests
        resp_mode = 0; resp_k = 2;
        vid_addr = 25'h0111; cp_addr = 25'h0222; cp_we = 0; cpu_addr = 25'h0333;
        ack_who.delete(); ack_at.delete();
        n0 = req_q.size();
        vid_req = 1; cp_req = 1; cpu_req = 1;
        serve(3, 100, 0);
        chk("sim_req_count", 32'(req_q.size() - n0), 3);
        if (ack_who.size() == 3) begin
            chk("sim_order0", 32'(ack_who[0]), 0);
            chk("sim_order1", 32'(ack_who[1]), 1);
            chk("sim_order2", 32'(ack_who[2]), 2);
        end
        chk("sim_vid_data", 32'(vid_data), 32'h0000A4B4);
        chk("sim_cp_dout", 32'(cp_dout), 32'h0000A787);
        chk("sim_cpu_dout", 32'(cpu_dout), 32'h0000A696);
        @(posedge clk_sys); #1;

        // starvation guard: video held continuously, CPU held
        resp_k = 1;
        vid_addr = 25'h0100; cpu_addr = 25'h2000;
        ack_who.delete(); ack_at.delete();
        vid_req = 1; cpu_req = 1;
        serve(5, 200, 1);
        vid_req = 0;
        if (ack_who.size() == 5) begin
            for (int i = 0; i < 4; i++) chk("starve_vid_grant", 32'(ack_who[i]), 0);
            chk("starve_cpu_grant", 32'(ack_who[4]), 2);
        end
        @(negedge clk_sys);
        chk("starve_cnt_cleared", 32'(dut.starve_q), 0);
        @(posedge clk_sys); #1;
        serve(0, 6, 0);

        // CPU byte write
        cpu_addr = 25'h0ABC; cpu_we = 1; cpu_wtbt = 2'b10; cpu_din = 16'h5A00;
        ack_who.delete(); ack_at.delete();
        cpu_req = 1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("bw_mem_req", 32'(mem_req), 1);
        chk("bw_mem_be", 32'(mem_be), 32'h2);
        chk("bw_mem_we", 32'(mem_we), 1);
        chk("bw_mem_din", 32'(mem_din), 32'h00005A00);
        @(posedge clk_sys); #1;
        serve(1, 50, 0);
        if (ack_who.size() > 0) chk("bw_ack_owner", 32'(ack_who[0]), 2);
        @(posedge clk_sys); #1;

        // timeout
        resp_on = 0;
        cpu_addr = 25'h0200; cpu_we = 0; cpu_wtbt = 2'b11; cpu_din = 0;
        ack_who.delete(); ack_at.delete();
        n0 = req_q.size();
        cpu_req = 1;
        serve(1, 150, 0);
        if (ack_at.size() > 0 && req_q.size() > n0)
            chk("tmo_ack_offset", 32'(ack_at[0] - req_q[n0]), 64);
        chk("tmo_data", 32'(cpu_dout), 32'h0000FFFF);
        chk("tmo_err_set", 32'(timeout_err), 1);
        kick_cnt++;
        count_acks(8, na);
        chk("tmo_late_ready_no_ack", 32'(na), 0);
        chk("tmo_err_sticky", 32'(timeout_err), 1);
        @(posedge clk_sys); #1;

        // reset during WAIT
        cpu_addr = 25'h0300;
        cpu_req = 1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk_sys);
            if (mem_req) found = 1;
        end
        chk("rw_issue_seen", 32'(found), 1);
        @(posedge clk_sys); #1;
        reset = 1; cpu_req = 0;
        @(posedge clk_sys); #1;
        reset = 0;
        @(negedge clk_sys);
        chk("rw_err_cleared", 32'(timeout_err), 0);
        chk("rw_mem_addr", 32'(mem_addr), 0);
        chk("rw_cpu_dout", 32'(cpu_dout), 0);
        kick_cnt++;
        count_acks(8, na);
        chk("rw_no_ack", 32'(na), 0);
        @(posedge clk_sys); #1;
        resp_on = 1; resp_mode = 1; resp_val = 16'h1234; resp_k = 1;
        ack_who.delete(); ack_at.delete();
        cpu_req = 1;
        serve(1, 50, 0);
        if (ack_who.size() > 0) chk("rw_next_owner", 32'(ack_who[0]), 2);
        chk("rw_next_data", 32'(cpu_dout), 32'h00001234);
        repeat (3) @(posedge clk_sys);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
